// File: rtl/mips16_pkg.sv
// Shared constants and FSM state type for the MIPS16 image loader.
// CHECKSUM_EN adds the trailer-check (CHK) and error (ERR) states.
package mips16_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned IMG_WORDS = 24;
  localparam int unsigned IMG_W     = WORD_W * IMG_WORDS;
  localparam int unsigned CNT_W     = 5;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_I,
    LOAD_D,
    RUN
`ifdef CHECKSUM_EN
    ,
    CHK,
    ERR
`endif
  } loader_state_t;

endpackage

// File: rtl/mips16_image_loader_if.sv
// Valid/ready word stream feeding the MIPS16 image loader.
interface mips16_image_loader_if #(
  parameter int unsigned WORD_W = 16
);

  logic              in_valid;
  logic [WORD_W-1:0] in_word;
  logic              in_ready;

  modport master (output in_valid, output in_word, input in_ready);
  modport slave  (input in_valid, input in_word, output in_ready);

endinterface

// File: rtl/mips16_word_bank.sv
// Flat image register: one WORD_W slot per address, synchronously cleared on rst.
module mips16_word_bank #(
  parameter  int unsigned WORD_W    = 16,
  parameter  int unsigned IMG_WORDS = 24,
  localparam int unsigned AW        = $clog2(IMG_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [AW-1:0]               addr,
  input  logic [WORD_W-1:0]           wdata,
  output logic [WORD_W*IMG_WORDS-1:0] image
);

  // Decoded per-slot write; out-of-range addresses write nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      image <= '0;
    end else begin
      for (int unsigned k = 0; k < IMG_WORDS; k++) begin
        if (we && (addr == k[AW-1:0])) begin
          image[k*WORD_W +: WORD_W] <= wdata;
        end
      end
    end
  end

endmodule

// File: rtl/mips16_image_loader.sv
// Streams 24 instruction + 24 data words into the MIPS16 flat images and holds the core
// in reset until both are loaded. Define CHECKSUM_EN for the XOR trailer check.
module mips16_image_loader
  import mips16_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  mips16_image_loader_if.slave stream,
  output logic [IMG_W-1:0]     out_instr,
  output logic [IMG_W-1:0]     out_data,
  output logic                 cpu_rst,
  output logic                 done,
  output logic                 err
);

  loader_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic             ready_q;
  logic             accept;
  logic             last;
  logic             we_i;
  logic             we_d;
`ifdef CHECKSUM_EN
  logic [WORD_W-1:0] csum;
`endif

  assign accept          = stream.in_valid && ready_q;
  assign last            = (cnt == LAST_IDX);
  assign we_i            = accept && (state == LOAD_I);
  assign we_d            = accept && (state == LOAD_D);
  assign stream.in_ready = ready_q;

  mips16_word_bank #(.WORD_W(WORD_W), .IMG_WORDS(IMG_WORDS)) u_instr_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (we_i),
    .addr  (cnt),
    .wdata (stream.in_word),
    .image (out_instr)
  );

  mips16_word_bank #(.WORD_W(WORD_W), .IMG_WORDS(IMG_WORDS)) u_data_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (we_d),
    .addr  (cnt),
    .wdata (stream.in_word),
    .image (out_data)
  );

  // ready/cpu_rst/done are registered alongside the state so they change on the
  // same edge as the transition that implies them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
      cpu_rst <= 1'b1;
      done    <= 1'b0;
`ifdef CHECKSUM_EN
      err     <= 1'b0;
      csum    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD_I;
            cnt     <= '0;
            ready_q <= 1'b1;
`ifdef CHECKSUM_EN
            csum    <= '0;
`endif
          end
        end
        LOAD_I: begin
          if (accept) begin
`ifdef CHECKSUM_EN
            csum <= csum ^ stream.in_word;
`endif
            if (last) begin
              state <= LOAD_D;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        LOAD_D: begin
          if (accept) begin
`ifdef CHECKSUM_EN
            csum <= csum ^ stream.in_word;
`endif
            if (last) begin
              cnt <= '0;
`ifdef CHECKSUM_EN
              state <= CHK;
`else
              state   <= RUN;
              ready_q <= 1'b0;
              cpu_rst <= 1'b0;
              done    <= 1'b1;
`endif
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        RUN: begin
          if (start) begin
            state   <= LOAD_I;
            cnt     <= '0;
            ready_q <= 1'b1;
            cpu_rst <= 1'b1;
            done    <= 1'b0;
`ifdef CHECKSUM_EN
            csum    <= '0;
`endif
          end
        end
`ifdef CHECKSUM_EN
        CHK: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (stream.in_word == csum) begin
              state   <= RUN;
              cpu_rst <= 1'b0;
              done    <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        ERR: begin
          if (start) begin
            state   <= LOAD_I;
            cnt     <= '0;
            ready_q <= 1'b1;
            err     <= 1'b0;
            csum    <= '0;
          end
        end
`endif
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          ready_q <= 1'b0;
          cpu_rst <= 1'b1;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifndef CHECKSUM_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mips16_image_loader.sv
// Directed-vector bench for mips16_image_loader (default and CHECKSUM_EN builds).
module tb_mips16_image_loader;

  logic         clk;
  logic         rst;
  logic         start;
  logic [383:0] out_instr;
  logic [383:0] out_data;
  logic         cpu_rst;
  logic         done;
  logic         err;

  int unsigned  vectors;
  int unsigned  miscompares;
  logic [15:0]  csum_model;

  mips16_image_loader_if #(.WORD_W(16)) bus ();

  mips16_image_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stream    (bus),
    .out_instr (out_instr),
    .out_data  (out_data),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [383:0] img(input logic [15:0] base);
    logic [383:0] v;
    v = '0;
    for (int k = 0; k < 24; k++) v[16*k +: 16] = base + 16'(k);
    return v;
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    csum_model = '0;
  endtask

  // Presents one word until accepted; gap inserts an idle (in_valid=0, junk data) cycle after.
  task automatic send_word(input logic [15:0] w, input bit gap);
    int n;
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      check("handshake_timeout", 384'(bus.in_ready), 384'd1);
    end else begin
      tick();
      csum_model = csum_model ^ w;
    end
    bus.in_valid = 1'b0;
    bus.in_word  = 16'hDEAD;
    if (gap) tick();
  endtask

  task automatic send_range(input logic [15:0] bi, input logic [15:0] bd,
                            input int first, input int count, input bit gap);
    for (int k = first; k < first + count; k++) begin
      if (k < 24) send_word(bi + 16'(k), gap);
      else        send_word(bd + 16'(k - 24), gap);
    end
  endtask

  task automatic send_trailer(input bit gap);
`ifdef CHECKSUM_EN
    send_word(csum_model, gap);
`else
    if (gap) tick();
`endif
  endtask

  task automatic check_images(input string tag, input logic [15:0] bi, input logic [15:0] bd);
    check({tag, "_instr"}, out_instr, img(bi));
    check({tag, "_data"},  out_data,  img(bd));
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    csum_model   = '0;
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_word  = '0;

    // 1: reset state
    repeat (3) tick();
    check("rst_cpu_rst",  384'(cpu_rst), 384'd1);
    check("rst_done",     384'(done), 384'd0);
    check("rst_in_ready", 384'(bus.in_ready), 384'd0);
    check("rst_err",      384'(err), 384'd0);
    check("rst_instr",    out_instr, '0);
    check("rst_data",     out_data, '0);
    rst = 1'b0;

    // in_valid in IDLE is not consumed
    bus.in_valid = 1'b1;
    bus.in_word  = 16'hBEEF;
    repeat (2) tick();
    bus.in_valid = 1'b0;
    check("idle_ignore", out_instr, '0);

    // 2: back-to-back load
    do_start();
    check("load_in_ready", 384'(bus.in_ready), 384'd1);
    send_range(16'h1000, 16'h2000, 0, 47, 1'b0);
    check("pre_last_cpu_rst", 384'(cpu_rst), 384'd1);
    check("pre_last_done",    384'(done), 384'd0);
`ifdef CHECKSUM_EN
    send_range(16'h1000, 16'h2000, 47, 1, 1'b0);
    send_trailer(1'b0);
`else
    send_range(16'h1000, 16'h2000, 47, 1, 1'b0);
`endif
    check("run_done",     384'(done), 384'd1);
    check("run_cpu_rst",  384'(cpu_rst), 384'd0);
    check("run_in_ready", 384'(bus.in_ready), 384'd0);
    check("run_err",      384'(err), 384'd0);
    check("instr_w0",     384'(out_instr[15:0]), 384'h1000);
    check("instr_w23",    384'(out_instr[383:368]), 384'h1017);
    check("data_w23",     384'(out_data[383:368]), 384'h2017);
    check_images("t2", 16'h1000, 16'h2000);

    // in_valid in RUN is not consumed
    bus.in_valid = 1'b1;
    bus.in_word  = 16'hBEEF;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    check_images("run_ignore", 16'h1000, 16'h2000);

    // 3: reset, then a load with in_valid toggling every cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t3_cleared", out_instr, '0);
    do_start();
    send_range(16'h1000, 16'h2000, 0, 48, 1'b1);
    send_trailer(1'b1);
    check("t3_done", 384'(done), 384'd1);
    check_images("t3", 16'h1000, 16'h2000);

    // 4: restart, reset after 10 instruction words, then fresh load
    do_start();
    send_range(16'h3000, 16'h3100, 0, 10, 1'b0);
    check("t4_partial_w9",  384'(out_instr[159:144]), 384'h3009);
    check("t4_partial_w10", 384'(out_instr[175:160]), 384'h100A);
    check("t4_partial_cpu", 384'(cpu_rst), 384'd1);
    check("t4_partial_done", 384'(done), 384'd0);
    rst = 1'b1;
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_word  = 16'h5555;
    tick();
    rst = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    check("t4_rst_instr", out_instr, '0);
    check("t4_rst_data",  out_data, '0);
    check("t4_rst_ready", 384'(bus.in_ready), 384'd0);
    check("t4_rst_cpu",   384'(cpu_rst), 384'd1);
    do_start();
    send_range(16'h1000, 16'h2000, 0, 48, 1'b0);
    send_trailer(1'b0);
    check("t4_done", 384'(done), 384'd1);
    check_images("t4", 16'h1000, 16'h2000);

    // 5: start ignored mid-LOAD_D; start in RUN restarts and overwrites
    do_start();
    send_range(16'h4000, 16'h5000, 0, 29, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_mid_ready", 384'(bus.in_ready), 384'd1);
    send_range(16'h4000, 16'h5000, 29, 19, 1'b0);
    send_trailer(1'b0);
    check("t5_done", 384'(done), 384'd1);
    check_images("t5", 16'h4000, 16'h5000);
    do_start();
    check("t5_restart_cpu",   384'(cpu_rst), 384'd1);
    check("t5_restart_done",  384'(done), 384'd0);
    check("t5_restart_ready", 384'(bus.in_ready), 384'd1);
    send_range(16'h6000, 16'h7000, 0, 3, 1'b0);
    check("t5_new_w2", 384'(out_instr[47:32]), 384'h6002);
    check("t5_old_w3", 384'(out_instr[63:48]), 384'h4003);
    send_range(16'h6000, 16'h7000, 3, 45, 1'b0);
    send_trailer(1'b0);
    check("t5_reload_done", 384'(done), 384'd1);
    check_images("t5_reload", 16'h6000, 16'h7000);

`ifdef CHECKSUM_EN
    // 6: bad trailer -> ERR, start recovers
    do_start();
    send_range(16'h1000, 16'h2000, 0, 48, 1'b0);
    check("t6_model_xor", 384'(csum_model), 384'h0000);
    send_word(16'h0001, 1'b0);
    check("t6_err",     384'(err), 384'd1);
    check("t6_cpu_rst", 384'(cpu_rst), 384'd1);
    check("t6_done",    384'(done), 384'd0);
    check("t6_ready",   384'(bus.in_ready), 384'd0);
    do_start();
    check("t6_err_clr", 384'(err), 384'd0);
    check("t6_ready2",  384'(bus.in_ready), 384'd1);
    send_range(16'h1000, 16'h2000, 0, 48, 1'b0);
    send_word(16'h0000, 1'b0);
    check("t6_ok_done", 384'(done), 384'd1);
    check("t6_ok_err",  384'(err), 384'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
